// File: rtl/mdio_master.sv
// ---------------------------------------------------------------------------
// mdio_master
//   Clause-22 MDIO management master. Takes one read/write command at a time,
//   serialises a single management frame on MDC/MDIO and returns one response.
//   MDC and MDIO are derived from the system clock by an internal divider.
//   The pad is driven through an external IOBUF:
//     mdio_o -> IOBUF.I, mdio_t -> IOBUF.T, IOBUF.O -> mdio_i.
//
// Parameters
//   CLK_DIV       clk cycles per MDC half-period (>= 2)
//   PREAMBLE_LEN  number of preamble ones before ST (0..32)
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   cmd_*         command request (valid/ready handshake, write flag,
//                 PHY address, register address, write data)
//   rsp_*         response: one-cycle valid pulse, read data, TA error flag
//   busy          frame in progress (inverse of cmd_ready)
//   mdc           management clock, idles low
//   mdio_o/_t/_i  MDIO drive value, tristate (1 = released), pad value
// ---------------------------------------------------------------------------
module mdio_master #(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int             DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0]     PRE_LAST = (PREAMBLE_LEN > 0) ? 6'(PREAMBLE_LEN - 1) : 6'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_STOP, S_ADDR, S_TA, S_DATA, S_TAIL, S_DONE
  } state_e;

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic          mdc_q;
  logic [5:0]    bit_cnt_q;    // bit index within the current state
  logic [31:0]   sh_q;         // ST..DATA bits still to be sent, MSB next
  logic          write_q;
  logic [15:0]   rx_q;
  logic          err_q;
  logic          mdio_o_q;
  logic          mdio_t_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic [15:0]   rsp_rdata_q;
  logic          rsp_err_q;

  // Frame body from ST to the end of DATA; read TA/DATA slots are never driven.
  logic [31:0] frame_d;
  assign frame_d = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                    2'b10, (cmd_write ? cmd_wdata : 16'h0000)};

  // End-of-bit decode: is this the last bit of the state, where do we go next,
  // and what does the following bit put on the pad.
  logic   last_bit_d;
  state_e nxt_state_d;
  state_e bit_state_d;
  logic   drv_o_d;
  logic   drv_t_d;
  logic   shift_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can leave it unassigned and infer a latch.
    last_bit_d  = 1'b0;
    nxt_state_d = state_q;
    drv_o_d     = 1'b1;
    drv_t_d     = 1'b1;
    shift_d     = 1'b0;

    case (state_q)
      S_PRE:  begin last_bit_d = (bit_cnt_q == PRE_LAST); nxt_state_d = S_STOP; end
      S_STOP: begin last_bit_d = (bit_cnt_q == 6'd3);     nxt_state_d = S_ADDR; end
      S_ADDR: begin last_bit_d = (bit_cnt_q == 6'd9);     nxt_state_d = S_TA;   end
      S_TA:   begin last_bit_d = (bit_cnt_q == 6'd1);     nxt_state_d = S_DATA; end
      S_DATA: begin last_bit_d = (bit_cnt_q == 6'd15);    nxt_state_d = S_TAIL; end
      S_TAIL: begin last_bit_d = 1'b1;                    nxt_state_d = S_DONE; end
      default: ;
    endcase

    bit_state_d = last_bit_d ? nxt_state_d : state_q;

    case (bit_state_d)
      S_PRE: begin
        drv_o_d = 1'b1;
        drv_t_d = 1'b0;
      end
      S_STOP, S_ADDR: begin
        drv_o_d = sh_q[31];
        drv_t_d = 1'b0;
        shift_d = 1'b1;
      end
      S_TA, S_DATA: begin
        // Reads release the bus from the first TA bit onwards.
        drv_o_d = write_q ? sh_q[31] : 1'b1;
        drv_t_d = ~write_q;
        shift_d = 1'b1;
      end
      default: ;  // idle bit and DONE: released, pulled high
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      mdc_q       <= 1'b0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      write_q     <= 1'b0;
      rx_q        <= '0;
      err_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the pre-edge value of every other register, as the hardware does.
      rsp_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            write_q     <= cmd_write;
            cmd_ready_q <= 1'b0;
            div_q       <= '0;
            mdc_q       <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            err_q       <= 1'b0;
            mdio_t_q    <= 1'b0;
            if (PREAMBLE_LEN > 0) begin
              state_q  <= S_PRE;
              mdio_o_q <= 1'b1;
              sh_q     <= frame_d;
            end else begin
              state_q  <= S_STOP;
              mdio_o_q <= frame_d[31];
              sh_q     <= {frame_d[30:0], 1'b0};
            end
          end
        end

        S_DONE: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!mdc_q) begin
              // Rising MDC: sample the pad for TA bit 2 and read data.
              mdc_q <= 1'b1;
              if (!write_q && state_q == S_TA && bit_cnt_q == 6'd1) err_q <= mdio_i;
              if (!write_q && state_q == S_DATA) rx_q <= {rx_q[14:0], mdio_i};
            end else begin
              // End of bit period: falling MDC starts the next bit.
              mdc_q    <= 1'b0;
              mdio_o_q <= drv_o_d;
              mdio_t_q <= drv_t_d;
              if (shift_d) sh_q <= {sh_q[30:0], 1'b0};
              if (last_bit_d) begin
                state_q   <= nxt_state_d;
                bit_cnt_q <= '0;
                if (nxt_state_d == S_DONE) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= write_q ? 16'h0000 : rx_q;
                  rsp_err_q   <= write_q ? 1'b0 : err_q;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = ~cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;

endmodule
